// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one I-mem request port between fetch (port 0) and aux (port 1); in-order
// responses are routed back through an outstanding-ID FIFO. Define IMARB_RR_EN for round-robin ties.
module imem_arbiter #(
    parameter int ABITS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] r0_req_addr_i,
    input  logic        r0_req_valid_i,
    output logic        r0_req_ready_o,
    output logic [63:0] r0_resp_rdata_o,
    output logic        r0_resp_valid_o,
    input  logic [63:0] r1_req_addr_i,
    input  logic        r1_req_valid_i,
    output logic        r1_req_ready_o,
    output logic [63:0] r1_resp_rdata_o,
    output logic        r1_resp_valid_o,
    output logic [63:0] m_req_addr_o,
    output logic        m_req_valid_o,
    input  logic        m_req_ready_i,
    input  logic [63:0] m_resp_rdata_i,
    input  logic        m_resp_valid_i,
    output logic        arb_orphan_o
);
    // state      | meaning
    // ARB_FREE   | no stalled request; grant recomputed every cycle
    // ARB_LOCKED | a request was presented but not accepted; grant held on lock_id_q
    localparam int DEPTH = 2**ABITS;

    typedef enum logic {ARB_FREE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

    arb_state_e       state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic             rr_last_q, rr_last_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS:0]   count_q, count_d;

    logic gnt, tie_gnt, gnt_valid, full, empty, push, pop, head_id;

`ifdef IMARB_RR_EN
    assign tie_gnt = ~rr_last_q;
`else
    // Fixed priority: rr_last_q is still tracked so both builds share one state set.
    logic unused_rr_last;
    assign unused_rr_last = rr_last_q;
    assign tie_gnt = 1'b0;
`endif

    assign full    = (count_q == (ABITS+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head_id = fifo_q[rd_ptr_q];

    always_comb begin
        gnt = 1'b0;
        if (state_q == ARB_LOCKED)
            gnt = lock_id_q;
        else if (r0_req_valid_i && r1_req_valid_i)
            gnt = tie_gnt;
        else if (r1_req_valid_i)
            gnt = 1'b1;
    end

    assign gnt_valid      = gnt ? r1_req_valid_i : r0_req_valid_i;
    assign m_req_valid_o  = gnt_valid && !full && !rst_i;
    assign m_req_addr_o   = rst_i ? '0 : (gnt ? r1_req_addr_i : r0_req_addr_i);
    assign push           = m_req_valid_o && m_req_ready_i;
    assign r0_req_ready_o = push && !gnt;
    assign r1_req_ready_o = push && gnt;

    assign pop             = m_resp_valid_i && !empty && !rst_i;
    assign r0_resp_valid_o = pop && !head_id;
    assign r1_resp_valid_o = pop && head_id;
    assign r0_resp_rdata_o = rst_i ? '0 : m_resp_rdata_i;
    assign r1_resp_rdata_o = rst_i ? '0 : m_resp_rdata_i;
    assign arb_orphan_o    = m_resp_valid_i && empty && !rst_i;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_last_d = rr_last_q;
        fifo_d    = fifo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (push) begin
            state_d          = ARB_FREE;
            rr_last_d        = gnt;
            fifo_d[wr_ptr_q] = gnt;
            wr_ptr_d         = wr_ptr_q + ABITS'(1);
        end else if (m_req_valid_o) begin
            state_d   = ARB_LOCKED;
            lock_id_d = gnt;
        end else if (state_q == ARB_LOCKED && !gnt_valid) begin
            state_d = ARB_FREE;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + ABITS'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (ABITS+1)'(1);
            2'b01:   count_d = count_q - (ABITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_FREE;
            lock_id_q <= 1'b0;
            rr_last_q <= 1'b1;
            fifo_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_last_q <= rr_last_d;
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

`ifndef SYNTHESIS
    logic [1:0]  stall_q;
    logic [63:0] stall_addr0_q, stall_addr1_q;

    // A stalled requester must present the same address until accepted or withdrawn.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= {r1_req_valid_i && !r1_req_ready_o, r0_req_valid_i && !r0_req_ready_o};
            if (stall_q[0] && r0_req_valid_i)
                assert (r0_req_addr_i == stall_addr0_q)
                    else $error("imem_arbiter: r0 address changed while stalled");
            if (stall_q[1] && r1_req_valid_i)
                assert (r1_req_addr_i == stall_addr1_q)
                    else $error("imem_arbiter: r1 address changed while stalled");
        end
        stall_addr0_q <= r0_req_addr_i;
        stall_addr1_q <= r1_req_addr_i;
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a queue-based reference model of grants and response routing.
module tb_imem_arbiter;
`ifdef IMARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] r0_addr, r1_addr, r0_rdata, r1_rdata, m_addr, m_rdata;
    logic        r0_valid, r1_valid, r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic        m_valid, m_ready, m_rvalid, orphan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .r0_req_addr_i  (r0_addr),
        .r0_req_valid_i (r0_valid),
        .r0_req_ready_o (r0_ready),
        .r0_resp_rdata_o(r0_rdata),
        .r0_resp_valid_o(r0_rvalid),
        .r1_req_addr_i  (r1_addr),
        .r1_req_valid_i (r1_valid),
        .r1_req_ready_o (r1_ready),
        .r1_resp_rdata_o(r1_rdata),
        .r1_resp_valid_o(r1_rvalid),
        .m_req_addr_o   (m_addr),
        .m_req_valid_o  (m_valid),
        .m_req_ready_i  (m_ready),
        .m_resp_rdata_i (m_rdata),
        .m_resp_valid_i (m_rvalid),
        .arb_orphan_o   (orphan)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding requester ids, held grant, last winner.
    int q[$];
    int held = -1;
    bit last = 1'b1;

    bit          nv0, nv1;
    logic [63:0] na0, na1;

    initial begin
        int vprob[5]  = '{70, 90, 90, 50, 100};
        int rdyprob[5] = '{80, 90, 30, 100, 100};
        int rspprob[5] = '{60, 20, 50, 90, 50};
        int rstprob[5] = '{2, 1, 2, 3, 0};
        bit          g, vg, e_mv, e_r0, e_r1, e_rv0, e_rv1, e_orph;
        logic [63:0] e_addr, e_data;

        rst = 1'b1; r0_valid = 0; r1_valid = 0; r0_addr = '0; r1_addr = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        nv0 = 0; nv1 = 0; na0 = '0; na1 = '0;

        for (int ph = 0; ph < 5; ph++) begin
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                r0_valid = nv0; r0_addr = na0;
                r1_valid = nv1; r1_addr = na1;
                rst      = (ph == 0 && cyc < 2) || ($urandom_range(0, 99) < rstprob[ph]);
                m_ready  = ($urandom_range(0, 99) < rdyprob[ph]);
                m_rvalid = ($urandom_range(0, 99) < rspprob[ph]);
                m_rdata  = {$urandom, $urandom};
                #1;
                g = 0; vg = 0; e_mv = 0; e_r0 = 0; e_r1 = 0;
                e_rv0 = 0; e_rv1 = 0; e_orph = 0; e_addr = '0; e_data = '0;
                if (!rst) begin
                    if (held >= 0)               g = held[0];
                    else if (r0_valid && r1_valid) g = RR_MODE ? !last : 1'b0;
                    else                         g = r1_valid;
                    vg     = g ? r1_valid : r0_valid;
                    e_mv   = vg && (q.size() < 4);
                    e_addr = g ? r1_addr : r0_addr;
                    e_r0   = e_mv && m_ready && !g;
                    e_r1   = e_mv && m_ready && g;
                    e_orph = m_rvalid && (q.size() == 0);
                    e_rv0  = m_rvalid && (q.size() > 0) && (q[0] == 0);
                    e_rv1  = m_rvalid && (q.size() > 0) && (q[0] == 1);
                    e_data = m_rdata;
                end
                check_eq("m_req_valid", 64'(m_valid), 64'(e_mv));
                check_eq("m_req_addr", m_addr, e_addr);
                check_eq("r0_req_ready", 64'(r0_ready), 64'(e_r0));
                check_eq("r1_req_ready", 64'(r1_ready), 64'(e_r1));
                check_eq("r0_resp_valid", 64'(r0_rvalid), 64'(e_rv0));
                check_eq("r1_resp_valid", 64'(r1_rvalid), 64'(e_rv1));
                check_eq("r0_resp_rdata", r0_rdata, e_data);
                check_eq("r1_resp_rdata", r1_rdata, e_data);
                check_eq("arb_orphan", 64'(orphan), 64'(e_orph));

                if (rst) begin
                    q.delete();
                    held = -1;
                    last = 1'b1;
                end else begin
                    if (m_rvalid && q.size() > 0) void'(q.pop_front());
                    if (e_mv && m_ready) begin
                        q.push_back(int'(g));
                        held = -1;
                        last = g;
                    end else if (e_mv) begin
                        held = int'(g);
                    end else if (held >= 0 && !(held == 1 ? r1_valid : r0_valid)) begin
                        held = -1;
                    end
                end

                // A stalled requester either holds its address or withdraws for a cycle.
                if (r0_valid && !e_r0) begin
                    nv0 = ($urandom_range(0, 9) != 0);
                end else begin
                    nv0 = ($urandom_range(0, 99) < vprob[ph]);
                    na0 = {$urandom, $urandom};
                end
                if (r1_valid && !e_r1) begin
                    nv1 = ($urandom_range(0, 9) != 0);
                end else begin
                    nv1 = ($urandom_range(0, 99) < vprob[ph]);
                    na1 = {$urandom, $urandom};
                end
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
